// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Sequencer between a CPU valid/ready request port and a 16-bit
//            word memory. Converts each accepted request into an access with
//            WAIT_CYCLES+1 enable-high cycles. Owns the shared data bus
//            turnaround. Returns each completion with a one-cycle rsp_valid
//            pulse. For reads, the pulse carries the captured read data.
// Ports    : clk, reset (sync, active-low)
//            req_valid/req_ready/req_write/req_addr/req_wdata  - CPU request
//            rsp_valid/rsp_rdata/rsp_error                     - CPU response
//            mem_address/mem_read_write/mem_enable/mem_data    - memory side
// Options  : MEM_CTRL_BOUNDS_EN - when defined, a request whose address is
//            above ADDR_LIMIT is rejected. It gets an immediate error
//            response and causes no memory activity.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT  = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_write,
    output logic              mem_enable,
    inout  wire  [DATA_W-1:0] mem_data
);

    localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

`ifdef MEM_CTRL_BOUNDS_EN
    localparam logic c_bounds_en = 1'b1;
`else
    localparam logic c_bounds_en = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [3:0]        r_cnt;
    logic              r_error;
    logic              w_accept;
    logic              w_reject;
    logic              w_drive;

    // An out-of-range request skips ACCESS entirely. The constant gate keeps
    // this term at zero when the bounds option is not built in.
    assign w_reject = c_bounds_en && (req_addr > ADDR_LIMIT);
    assign w_accept = (r_state == ST_IDLE) && req_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = w_reject ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= 4'd0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= c_wait;
                r_error <= w_reject;
                if (w_reject) begin
                    r_rdata <= '0;
                end
            end
            if (r_state == ST_ACCESS) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else if (!r_write) begin
                    // Last ACCESS edge. The memory has driven the bus since
                    // the first ACCESS cycle, so the data is settled here.
                    r_rdata <= mem_data;
                end
            end
        end
    end

    // The bus is driven only while a write is in ACCESS. The state after
    // ACCESS is always RESP with enable low, so the turnaround never
    // overlaps with the memory driving the bus.
    assign w_drive        = (r_state == ST_ACCESS) && r_write;
    assign mem_data       = w_drive ? r_wdata : {DATA_W{1'bz}};

    assign req_ready      = (r_state == ST_IDLE);
    assign rsp_valid      = (r_state == ST_RESP);
    assign rsp_error      = (r_state == ST_RESP) && r_error;
    assign rsp_rdata      = r_rdata;
    assign mem_enable     = (r_state == ST_ACCESS);
    assign mem_read_write = !w_drive;
    assign mem_address    = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl. Instance A
//            uses WAIT_CYCLES=1 and instance B uses WAIT_CYCLES=3. Each
//            instance has its own behavioural word memory. One request port
//            is steered to the instance selected by 'sel'.
// Options  : MEM_CTRL_BOUNDS_EN selects the expected out-of-range behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wire        valid_a = req_valid && !sel;
    wire        valid_b = req_valid && sel;
    wire        ready_a, rspv_a, err_a, en_a, rw_a;
    wire        ready_b, rspv_b, err_b, en_b, rw_b;
    wire [15:0] rd_a, addr_a, bus_a;
    wire [15:0] rd_b, addr_b, bus_b;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1), .ADDR_LIMIT(16'h00FF)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(valid_a), .req_ready(ready_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv_a), .rsp_rdata(rd_a), .rsp_error(err_a),
        .mem_address(addr_a), .mem_read_write(rw_a), .mem_enable(en_a),
        .mem_data(bus_a)
    );

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3), .ADDR_LIMIT(16'h00FF)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(valid_b), .req_ready(ready_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv_b), .rsp_rdata(rd_b), .rsp_error(err_b),
        .mem_address(addr_b), .mem_read_write(rw_b), .mem_enable(en_b),
        .mem_data(bus_b)
    );

    // Behavioural memories: drive the bus for reads while enabled, and
    // store the bus value on each write edge.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    always @(posedge clk) begin
        if (en_a && !rw_a) mem_a[addr_a[7:0]] <= bus_a;
        if (en_b && !rw_b) mem_b[addr_b[7:0]] <= bus_b;
    end

    assign bus_a = (en_a && rw_a) ? mem_a[addr_a[7:0]] : 16'hzzzz;
    assign bus_b = (en_b && rw_b) ? mem_b[addr_b[7:0]] : 16'hzzzz;

    wire        w_ready = sel ? ready_b : ready_a;
    wire        w_rspv  = sel ? rspv_b  : rspv_a;
    wire        w_err   = sel ? err_b   : err_a;
    wire        w_en    = sel ? en_b    : en_a;
    wire        w_rw    = sel ? rw_b    : rw_a;
    wire [15:0] w_rd    = sel ? rd_b    : rd_a;
    wire [15:0] w_addr  = sel ? addr_b  : addr_a;
    wire [15:0] w_bus   = sel ? bus_b   : bus_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A released bus reads as Z on a 4-state simulator and as 0 on a 2-state one.
    function automatic bit bus_idle(input logic [15:0] b);
        return (b === 16'hzzzz) || (b === 16'h0000);
    endfunction

    // Issue one request and follow it to its response. In each cycle after
    // the accept edge, this checks enable, address, direction, bus ownership
    // and ready.
    task automatic do_access(input string tag, input bit wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input int exp_en, input int exp_k,
                             input bit exp_err, input bit chk_rd, input logic [15:0] exp_rd);
        int en_cnt = 0;
        int rsp_k  = 0;
        int bad    = 0;
        @(negedge clk);
        check({tag, ":ready"}, 32'(w_ready), 32'd1);
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        // The request port changes after accept. This must not affect the
        // access in flight.
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 16'hDEAD;
        req_wdata = 16'h0F0F;
        for (int k = 1; k <= 20 && rsp_k == 0; k++) begin
            @(negedge clk);
            if (w_en) begin
                en_cnt++;
                if (w_addr !== addr || w_rw !== !wr) bad++;
                if (wr && w_bus !== wdata) bad++;
            end else if (!bus_idle(w_bus)) begin
                bad++;
            end
            if (w_ready) bad++;
            if (w_rspv) begin
                rsp_k = k;
                check({tag, ":err"}, 32'(w_err), 32'(exp_err));
                if (chk_rd) check({tag, ":rdata"}, 32'(w_rd), 32'(exp_rd));
            end
        end
        check({tag, ":en_cycles"}, 32'(en_cnt), 32'(exp_en));
        check({tag, ":rsp_cycle"}, 32'(rsp_k), 32'(exp_k));
        check({tag, ":bus_ctl"}, 32'(bad), 32'd0);
        @(negedge clk);
        check({tag, ":rsp_pulse"}, 32'(w_rspv), 32'd0);
        if (chk_rd) check({tag, ":rdata_hold"}, 32'(w_rd), 32'(exp_rd));
    endtask

    initial begin
        int acc, rsps, rises, stray;
        logic prev_en;

        reset     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst:ready", 32'(ready_a), 32'd1);
        check("rst:rsp_valid", 32'(rspv_a), 32'd0);
        check("rst:rsp_error", 32'(err_a), 32'd0);
        check("rst:rdata", 32'(rd_a), 32'd0);
        check("rst:enable", 32'(en_a), 32'd0);
        check("rst:read_write", 32'(rw_a), 32'd1);
        check("rst:address", 32'(addr_a), 32'd0);
        check("rst:bus", 32'(bus_idle(bus_a)), 32'd1);
        reset = 1'b1;

        // W=1: write then read back.
        sel = 1'b0;
        do_access("w1_wr", 1'b1, 16'h0010, 16'hBEEF, 2, 3, 1'b0, 1'b0, 16'h0000);
        do_access("w1_rd", 1'b0, 16'h0010, 16'h0000, 2, 3, 1'b0, 1'b1, 16'hBEEF);

        // W=3: preload, then read with wait states.
        sel = 1'b1;
        do_access("w3_wr", 1'b1, 16'h0004, 16'h1234, 4, 5, 1'b0, 1'b0, 16'h0000);
        do_access("w3_rd", 1'b0, 16'h0004, 16'h0000, 4, 5, 1'b0, 1'b1, 16'h1234);

        // Bus turnaround: a write is immediately followed by a read.
        sel = 1'b0;
        do_access("ta_pre", 1'b1, 16'h0000, 16'h5555, 2, 3, 1'b0, 1'b0, 16'h0000);
        do_access("ta_wr", 1'b1, 16'h0001, 16'hAAAA, 2, 3, 1'b0, 1'b0, 16'h0000);
        do_access("ta_rd", 1'b0, 16'h0000, 16'h0000, 2, 3, 1'b0, 1'b1, 16'h5555);

        // Busy: req_valid is held high. Exactly two handshakes give exactly
        // two accesses.
        acc = 0; rsps = 0; rises = 0; prev_en = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0010;
        @(negedge clk);
        req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (w_rspv) rsps++;
            if (w_en && !prev_en) rises++;
            prev_en = w_en;
            if (w_ready && req_valid) begin
                acc++;
                if (acc == 2) begin
                    @(posedge clk);
                    #1 req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("busy:accepts", 32'(acc), 32'd2);
        check("busy:responses", 32'(rsps), 32'd2);
        check("busy:accesses", 32'(rises), 32'd2);
        check("busy:rdata", 32'(rd_a), 32'hBEEF);

        // Reset in the middle of a W=3 read.
        sel = 1'b1;
        @(negedge clk);
        req_write = 1'b0;
        req_addr  = 16'h0004;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mrst:in_access", 32'(en_b), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mrst:enable", 32'(en_b), 32'd0);
        check("mrst:rsp_valid", 32'(rspv_b), 32'd0);
        check("mrst:ready", 32'(ready_b), 32'd1);
        check("mrst:bus", 32'(bus_idle(bus_b)), 32'd1);
        check("mrst:rdata", 32'(rd_b), 32'd0);
        reset = 1'b1;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rspv_b || en_b) stray++;
        end
        check("mrst:no_response", 32'(stray), 32'd0);
        do_access("mrst_rd", 1'b0, 16'h0004, 16'h0000, 4, 5, 1'b0, 1'b1, 16'h1234);

        // Address 0x0100 is above ADDR_LIMIT=0x00FF.
        sel = 1'b0;
`ifdef MEM_CTRL_BOUNDS_EN
        do_access("oob_rd", 1'b0, 16'h0100, 16'h0000, 0, 1, 1'b1, 1'b1, 16'h0000);
`else
        // Without bounds checking the address is passed through. The model
        // memory decodes 8 bits, so 0x0100 aliases word 0x00 (holds 0x5555).
        do_access("oob_rd", 1'b0, 16'h0100, 16'h0000, 2, 3, 1'b0, 1'b1, 16'h5555);
`endif
        do_access("post_rd", 1'b0, 16'h0010, 16'h0000, 2, 3, 1'b0, 1'b1, 16'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
